// File: rtl/ntt_bfly_engine_pkg.sv
// Shared definitions for the NTT butterfly engine: op mode codes, Barrett constant
// and pipeline latency helpers.
package ntt_bfly_engine_pkg;

    typedef enum logic [1:0] {
        NTT_CT    = 2'b00,
        NTT_GS    = 2'b01,
        NTT_SCALE = 2'b10,
        NTT_NOP   = 2'b11
    } ntt_mode_e;

    // floor(2**(2w) / q), the Barrett constant for a 2w-bit product
    function automatic logic [127:0] ntt_barrett_mu(input int w, input int unsigned q);
        logic [127:0] num;
        num = 128'd1 << (2 * w);
        return num / {96'd0, q};
    endfunction

    function automatic int ntt_lat(input int mul_stages);
        return mul_stages + 3;
    endfunction

endpackage

// File: rtl/ntt_bfly_engine_if.sv
// Request, load and dump channels of the NTT butterfly engine.
interface ntt_bfly_engine_if #(
    parameter int W      = 30,
    parameter int ADDR_W = 9
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_mode;
    logic [ADDR_W-1:0] op_upper_addr;
    logic [ADDR_W-1:0] op_lower_addr;
    logic [W-1:0]      op_twiddle;
    logic              ld_we;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [W-1:0]      ld_upper;
    logic [W-1:0]      ld_lower;
    logic              rd_en;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [W-1:0]      rd_upper;
    logic [W-1:0]      rd_lower;
    logic              busy;

    modport master (
        output op_valid, op_mode, op_upper_addr, op_lower_addr, op_twiddle,
        output ld_we, ld_addr, ld_upper, ld_lower, rd_en, rd_addr,
        input  op_ready, ld_ready, rd_ready, rd_valid, rd_upper, rd_lower, busy
    );

    modport slave (
        input  op_valid, op_mode, op_upper_addr, op_lower_addr, op_twiddle,
        input  ld_we, ld_addr, ld_upper, ld_lower, rd_en, rd_addr,
        output op_ready, ld_ready, rd_ready, rd_valid, rd_upper, rd_lower, busy
    );

endinterface

// File: rtl/ntt_bfly_engine_mul.sv
// Pipelined modular multiplier a*b % Q with Barrett reduction; latency MUL_STAGES cycles,
// no valid tracking (the caller carries control alongside).
module mod_mul_barrett
    import ntt_bfly_engine_pkg::*;
#(
    parameter int          W          = 30,
    parameter int unsigned Q          = 998244353,
    parameter int          MUL_STAGES = 3
) (
    input  logic         clk,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    localparam logic [2*W-1:0] MU  = (2*W)'(ntt_barrett_mu(W, Q));
    localparam logic [W+1:0]   QE  = (W+2)'(Q);
    localparam logic [W+1:0]   QE2 = QE << 1;

    // Quotient estimate floor(x*MU / 2**2W) undershoots by at most one, so r < 2Q
    function automatic logic [W-1:0] barrett_reduce(input logic [2*W-1:0] x);
        logic [4*W-1:0] qx;
        logic [2*W-1:0] qt;
        logic [3*W+1:0] qq;
        logic [W+1:0]   r;
        qx = {{(2*W){1'b0}}, x} * {{(2*W){1'b0}}, MU};
        qt = (2*W)'(qx >> (2*W));
        qq = {{(W+2){1'b0}}, qt} * {{(2*W){1'b0}}, QE};
        r  = (W+2)'(x) - (W+2)'(qq);
        if (r >= QE2)
            r = r - QE2;
        else if (r >= QE)
            r = r - QE;
        return r[W-1:0];
    endfunction

    logic [2*W-1:0] prod_p0;
    logic [W-1:0]   red;

    // product register; reduction follows, then retiming registers
    always_ff @(posedge clk) begin
        prod_p0 <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end

    assign red = barrett_reduce(prod_p0);

    generate
        if (MUL_STAGES == 1) begin : g_one
            assign y = red;
        end else begin : g_dly
            logic [W-1:0] dly_p [MUL_STAGES-1];
            always_ff @(posedge clk) begin
                dly_p[0] <= red;
                for (int i = 1; i < MUL_STAGES-1; i++)
                    dly_p[i] <= dly_p[i-1];
            end
            assign y = dly_p[MUL_STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/ntt_bfly_engine.sv
// NTT butterfly engine: one CT / GS / SCALE butterfly per cycle over two private
// coefficient banks, with a read-after-write interlock on in-flight bank addresses.
module ntt_bfly_engine
    import ntt_bfly_engine_pkg::*;
#(
    parameter int          W          = 30,
    parameter int unsigned Q          = 998244353,
    parameter int          ADDR_W     = 9,
    parameter int          MUL_STAGES = 3
) (
    input logic              clk,
    input logic              rst_n,
    ntt_bfly_engine_if.slave bus
);
    localparam int         LAT = ntt_lat(MUL_STAGES);
    localparam int         PS  = MUL_STAGES + 1;
    localparam logic [W:0] QX  = (W+1)'(Q);

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= QX)
            s = s - QX;
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[W])
            d = d + QX;
        return d[W-1:0];
    endfunction

    logic [W-1:0]      mem_u [2**ADDR_W];
    logic [W-1:0]      mem_l [2**ADDR_W];
    logic [W-1:0]      u_rd, l_rd;
    logic              hazard, op_acc, ld_acc, wb_en, we, rd_vld;
    logic [ADDR_W-1:0] ra_u, ra_l, wa_u, wa_l;
    logic [W-1:0]      wd_u, wd_l;

    logic [LAT-1:0]    vld_p;
    ntt_mode_e         mode_p [LAT];
    logic [ADDR_W-1:0] ua_p   [LAT];
    logic [ADDR_W-1:0] la_p   [LAT];
    logic [W-1:0]      tw_p0, tw_p1, x_p1, m0a_p1, m1a_p1;
    logic [W-1:0]      x_pm   [MUL_STAGES];
    logic [W-1:0]      t0, t1;
    logic [W-1:0]      wb_u_p2, wb_l_p2;

    // Every stage from bank read to writeback counts: a read issued on the writeback edge sees old data
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            if (vld_p[k] && (mode_p[k] != NTT_NOP) &&
                ((ua_p[k] == bus.op_upper_addr) || (la_p[k] == bus.op_lower_addr)))
                hazard = 1'b1;
        end
    end

    assign bus.op_ready = ~hazard & ~bus.ld_we;
    assign op_acc       = bus.op_valid & bus.op_ready;
    assign bus.busy     = |vld_p;
    assign bus.ld_ready = ~bus.busy & ~op_acc;
    assign ld_acc       = bus.ld_we & bus.ld_ready;
    assign bus.rd_ready = ~op_acc;

    assign bus.rd_valid = rd_vld;
    assign bus.rd_upper = rd_vld ? u_rd : '0;
    assign bus.rd_lower = rd_vld ? l_rd : '0;

    // Loads need an empty pipeline, so they never collide with a writeback
    assign ra_u  = op_acc ? bus.op_upper_addr : bus.rd_addr;
    assign ra_l  = op_acc ? bus.op_lower_addr : bus.rd_addr;
    assign wb_en = vld_p[LAT-1] && (mode_p[LAT-1] != NTT_NOP);
    assign we    = ld_acc | wb_en;
    assign wa_u  = ld_acc ? bus.ld_addr  : ua_p[LAT-1];
    assign wa_l  = ld_acc ? bus.ld_addr  : la_p[LAT-1];
    assign wd_u  = ld_acc ? bus.ld_upper : wb_u_p2;
    assign wd_l  = ld_acc ? bus.ld_lower : wb_l_p2;

    // S0: bank read
    always_ff @(posedge clk) begin
        if (we) begin
            mem_u[wa_u] <= wd_u;
            mem_l[wa_l] <= wd_l;
        end
        u_rd <= mem_u[ra_u];
        l_rd <= mem_l[ra_l];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p  <= '0;
            rd_vld <= 1'b0;
        end else begin
            vld_p  <= {vld_p[LAT-2:0], op_acc};
            rd_vld <= bus.rd_en & bus.rd_ready;
        end
    end

    always_ff @(posedge clk) begin
        mode_p[0] <= ntt_mode_e'(bus.op_mode);
        ua_p[0]   <= bus.op_upper_addr;
        la_p[0]   <= bus.op_lower_addr;
        tw_p0     <= bus.op_twiddle;
        for (int k = 1; k < LAT; k++) begin
            mode_p[k] <= mode_p[k-1];
            ua_p[k]   <= ua_p[k-1];
            la_p[k]   <= la_p[k-1];
        end
    end

    // S1: pre-add/sub and multiplier operand select
    always_ff @(posedge clk) begin
        tw_p1  <= tw_p0;
        m1a_p1 <= u_rd;
        m0a_p1 <= (mode_p[0] == NTT_GS) ? mod_sub(u_rd, l_rd) : l_rd;
        x_p1   <= (mode_p[0] == NTT_GS) ? mod_add(u_rd, l_rd) : u_rd;
    end

    // S2..S(1+MUL_STAGES): multiply
    mod_mul_barrett #(.W(W), .Q(Q), .MUL_STAGES(MUL_STAGES)) u_mul0 (
        .clk (clk),
        .a   (m0a_p1),
        .b   (tw_p1),
        .y   (t0)
    );

    mod_mul_barrett #(.W(W), .Q(Q), .MUL_STAGES(MUL_STAGES)) u_mul1 (
        .clk (clk),
        .a   (m1a_p1),
        .b   (tw_p1),
        .y   (t1)
    );

    always_ff @(posedge clk) begin
        x_pm[0] <= x_p1;
        for (int k = 1; k < MUL_STAGES; k++)
            x_pm[k] <= x_pm[k-1];
    end

    // S(LAT-1): post-add/sub, result registered for the writeback edge
    always_ff @(posedge clk) begin
        case (mode_p[PS])
            NTT_CT: begin
                wb_u_p2 <= mod_add(x_pm[MUL_STAGES-1], t0);
                wb_l_p2 <= mod_sub(x_pm[MUL_STAGES-1], t0);
            end
            NTT_GS: begin
                wb_u_p2 <= x_pm[MUL_STAGES-1];
                wb_l_p2 <= t0;
            end
            default: begin
                wb_u_p2 <= t1;
                wb_l_p2 <= t0;
            end
        endcase
    end

endmodule
